banked_data_ram: RTL and testbench

- Parametrised successor to the single-bank polynomial coefficient store.
- Address space is split across NUM_BANKS = 2**BANK_BITS interleaved banks.
- Has a synchronous reset, a self-clearing init sequence that zeroes all rows (all banks in parallel), a read-valid strobe and same-address write-to-read resolution.
- Sits between the NTT/poly-mul datapath and its coefficient producers: one write port, one read port, one-cycle read latency.

---
 rtl/banked_data_ram.sv | 172 +++++++++++++++++
 tb/tb_banked_data_ram.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/banked_data_ram.sv
// banked_data_ram
//   Coefficient store for the NTT / poly-mul datapath with one write port and
//   one read port. The word address space is interleaved across
//   NUM_BANKS = 2**BANK_BITS banks: bank = addr[BANK_BITS-1:0],
//   row = addr[ADDR_WIDTH-1:BANK_BITS]. After reset an init sequence clears
//   one row in every bank per enabled cycle; requests are ignored until it
//   completes. Reads have one cycle of latency.
//
//   Optional build macro BANKED_RAM_WR_FWD_EN:
//     defined   - a same-edge write and read of the same address returns the
//                 new write data (write-first).
//     undefined - the same case returns the previously stored word
//                 (read-first). The write commits in both builds.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, priority over en
//   en         in   global enable; 0 freezes memory, state and rd_data
//   wr_en      in   write request
//   wr_addr    in   [ADDR_WIDTH-1:0] write word address
//   wr_data    in   [DATA_WIDTH-1:0] write data
//   rd_en      in   read request
//   rd_addr    in   [ADDR_WIDTH-1:0] read word address
//   rd_data    out  [DATA_WIDTH-1:0] read data, holds between reads
//   rd_valid   out  one-cycle strobe per accepted read
//   init_busy  out  high while the clear sequence runs
module banked_data_ram #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 256,
  parameter int BANK_BITS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  init_busy
);

  localparam int NUM_BANKS = 2 ** BANK_BITS;
  localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
  localparam int ROWS      = 2 ** ROW_BITS;

  typedef enum logic {INIT, READY} state_t;

  state_t                state_reg;
  logic [ROW_BITS-1:0]   row_cnt_reg;
  logic                  init_busy_reg;
  logic                  rd_valid_reg;
  // rd_data reads as zero from reset until the first accepted read, so the
  // bank output registers themselves need no reset.
  logic                  rd_zero_reg;
  logic [BANK_BITS-1:0]  rd_bank_reg;

  logic [BANK_BITS-1:0]  wr_bank;
  logic [ROW_BITS-1:0]   wr_row;
  logic [BANK_BITS-1:0]  rd_bank;
  logic [ROW_BITS-1:0]   rd_row;
  logic                  init_wr;
  logic                  wr_ok;
  logic                  rd_ok;

  logic [DATA_WIDTH-1:0] bank_q [NUM_BANKS];

  assign wr_bank = wr_addr[BANK_BITS-1:0];
  assign wr_row  = wr_addr[ADDR_WIDTH-1:BANK_BITS];
  assign rd_bank = rd_addr[BANK_BITS-1:0];
  assign rd_row  = rd_addr[ADDR_WIDTH-1:BANK_BITS];

  assign init_wr = !rst && en && (state_reg == INIT);
  assign wr_ok   = !rst && en && (state_reg == READY) && wr_en;
  assign rd_ok   = !rst && en && (state_reg == READY) && rd_en;

  // Control FSM: init row counter, valid strobe and output bank select.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= INIT;
      row_cnt_reg   <= '0;
      init_busy_reg <= 1'b1;
      rd_valid_reg  <= 1'b0;
      rd_zero_reg   <= 1'b1;
      rd_bank_reg   <= '0;
    end else if (en) begin
      case (state_reg)
        INIT: begin
          rd_valid_reg <= 1'b0;
          if (&row_cnt_reg) begin
            state_reg     <= READY;
            init_busy_reg <= 1'b0;
            row_cnt_reg   <= '0;
          end else begin
            row_cnt_reg <= row_cnt_reg + 1'b1;
          end
        end
        READY: begin
          rd_valid_reg <= rd_en;
          if (rd_en) begin
            rd_bank_reg <= rd_bank;
            rd_zero_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= INIT;
        end
      endcase
    end else begin
      rd_valid_reg <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [ROWS];
      logic [DATA_WIDTH-1:0] q_reg;
      logic                  we;
      logic [ROW_BITS-1:0]   waddr;
      logic [DATA_WIDTH-1:0] wdata;
      logic                  re;

      // Init clears the counter row in every bank at once; otherwise only
      // the addressed bank takes the write.
      always_comb begin
        we    = 1'b0;
        waddr = wr_row;
        wdata = wr_data;
        if (init_wr) begin
          we    = 1'b1;
          waddr = row_cnt_reg;
          wdata = '0;
        end else if (wr_ok && (wr_bank == BANK_BITS'(gi))) begin
          we = 1'b1;
        end
      end

      assign re = rd_ok && (rd_bank == BANK_BITS'(gi));

      always_ff @(posedge clk) begin
        if (we) begin
          mem[waddr] <= wdata;
        end
        if (re) begin
`ifdef BANKED_RAM_WR_FWD_EN
          // Write-first bypass for a same-row write in this bank.
          if (we && (waddr == rd_row)) begin
            q_reg <= wdata;
          end else begin
            q_reg <= mem[rd_row];
          end
`else
          // Read-first: the old word is sampled before the write lands.
          q_reg <= mem[rd_row];
`endif
        end
      end

      assign bank_q[gi] = q_reg;
    end
  endgenerate

  // Only the bank that served the last read has a meaningful register, so
  // selecting it by the registered bank index also gives the hold behaviour.
  assign rd_data   = rd_zero_reg ? '0 : bank_q[rd_bank_reg];
  assign rd_valid  = rd_valid_reg;
  assign init_busy = init_busy_reg;

endmodule

// File: tb/tb_banked_data_ram.sv
// tb_banked_data_ram
//   Randomised and directed stimulus for banked_data_ram against a flat-array
//   reference model. Expected reads go into a queue with their due cycle; a
//   negedge monitor pops and compares whenever rd_valid is seen. The driver
//   also checks init_busy and the held rd_data value after every edge.
module tb_banked_data_ram;

  localparam int AW = 7;
  localparam int DW = 256;
  localparam int DEPTH = 2 ** AW;
  localparam int INIT_CYCLES = 32;

`ifdef BANKED_RAM_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          init_busy;

  banked_data_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_BITS(2)) dut (
    .clk(clk), .rst(rst), .en(en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .init_busy(init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] last_rd;
  int            init_left;
  int            checks = 0;
  int            errors = 0;
  bit            done = 1'b0;

  // Monitor: every rd_valid must match the oldest outstanding expectation at
  // exactly its due cycle; an overdue expectation is a missing strobe.
  always @(negedge clk) begin
    if (!done) begin
      if (rd_valid === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL rd_valid_unexpected cyc=%0d got rd_valid=1 required 0", cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (rd_data !== e.data || e.due != cyc) begin
            errors++;
            $display("FAIL read_data addr=%0d cyc=%0d got %h required %h due=%0d",
                     e.addr, cyc, rd_data, e.data, e.due);
          end else begin
            $display("read addr=%0d cyc=%0d data=%h ok", e.addr, cyc, rd_data);
          end
        end
      end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        exp_t e;
        checks++;
        errors++;
        e = sb_q.pop_front();
        $display("FAIL rd_valid_missing addr=%0d cyc=%0d got rd_valid=%b required 1",
                 e.addr, cyc, rd_valid);
      end
    end
  end

  // One clock: drive inputs, advance the model for the coming edge, then
  // check the visible state 1 time unit after that edge.
  task automatic step(input logic r, input logic e,
                      input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic re, input logic [AW-1:0] ra);
    rst = r; en = e; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      init_left = INIT_CYCLES;
      last_rd   = '0;
    end else if (e) begin
      if (init_left > 0) begin
        init_left--;
      end else begin
        if (re) begin
          exp_t x;
          x.data = (FWD && we && wa == ra) ? wd : model_mem[ra];
          x.due  = cyc + 1;
          x.addr = ra;
          sb_q.push_back(x);
          last_rd = x.data;
        end
        if (we) model_mem[wa] = wd;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (init_busy !== (init_left > 0)) begin
      errors++;
      $display("FAIL init_busy cyc=%0d got %b required %b", cyc, init_busy, init_left > 0);
    end
    checks++;
    if (rd_data !== last_rd) begin
      errors++;
      $display("FAIL rd_data_hold cyc=%0d got %h required %h", cyc, rd_data, last_rd);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b0, 1'b1, 1'b1, a, d, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, a);
  endtask

  task automatic reset_and_init();
    step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < INIT_CYCLES; i++) begin
      // Requests during init (a write and a read at cycle 5) must be ignored.
      if (i == 4) step(1'b0, 1'b1, 1'b1, 7'd7, DW'(32'h99), 1'b1, 7'd7);
      else        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    end
  endtask

  initial begin
    logic [DW-1:0] a5;
    logic          r_e, r_we, r_re, r_rst;
    logic [AW-1:0] r_wa, r_ra;
    logic [DW-1:0] r_wd;

    init_left = INIT_CYCLES;
    last_rd   = '0;
    a5 = {32{8'hA5}};

    // Clear sequence and post-init reads of cleared words.
    reset_and_init();
    rd(7'd0); rd(7'd5); rd(7'd127); rd(7'd7);
    idle(2);

    // Writes across banks, then back-to-back reads.
    wr(7'd3, a5); wr(7'd4, DW'(32'h1234)); wr(7'd127, DW'(32'hFF));
    rd(7'd3); rd(7'd4); rd(7'd127);
    idle(2);

    // Same-address collision, then a plain read-back.
    wr(7'd10, DW'(32'h55));
    step(1'b0, 1'b1, 1'b1, 7'd10, DW'(32'hAA), 1'b1, 7'd10);
    rd(7'd10);
    idle(1);

    // Enable stall with a pending read request, then release.
    rd(7'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 7'd4, DW'(32'hDEAD), 1'b1, 7'd4);
    rd(7'd4);
    idle(2);

    // Randomised traffic over a small window so collisions and bank
    // conflicts are frequent; rare resets restart init.
    for (int n = 0; n < 400; n++) begin
      r_rst = ($urandom_range(0, 149) == 0);
      r_e   = ($urandom_range(0, 7) != 0);
      r_we  = $urandom_range(0, 1);
      r_re  = $urandom_range(0, 1);
      r_wa  = AW'($urandom_range(0, 15));
      r_ra  = ($urandom_range(0, 3) == 0) ? r_wa : AW'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) r_ra = AW'($urandom_range(0, DEPTH - 1));
      r_wd  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step(r_rst, r_e, r_we, r_wa, r_wd, r_re, r_ra);
    end
    while (init_left > 0) idle(1);
    idle(2);

    // Reset mid-operation with a read issued the edge before and one on it.
    wr(7'd20, DW'(32'h77));
    rd(7'd20);
    step(1'b1, 1'b1, 1'b1, 7'd21, DW'(32'h66), 1'b1, 7'd20);
    for (int i = 0; i < INIT_CYCLES; i++) idle(1);
    rd(7'd20); rd(7'd21);
    idle(3);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL outstanding_reads got %0d required 0", sb_q.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
